// File: rtl/voxel_seq_pkg.sv
// voxel_seq_pkg: shared states, register map and camera reset values for the frame sequencer
package voxel_seq_pkg;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WGEN    = 3'd1,
    S_WWAIT   = 3'd2,
    S_READY   = 3'd3,
    S_LAUNCH  = 3'd4,
    S_RUN     = 3'd5,
    S_ADVANCE = 3'd6
  } seq_state_e;
  localparam logic [7:0] ADDR_CTRL = 8'hF0;
  localparam logic [7:0] ADDR_MASK = 8'hF1;
  localparam logic [3:0] F_X       = 4'd0;
  localparam logic [3:0] F_Y       = 4'd1;
  localparam logic [3:0] F_Z       = 4'd2;
  localparam logic [3:0] F_DIR_X   = 4'd3;
  localparam logic [3:0] F_DIR_Y   = 4'd4;
  localparam logic [3:0] F_DIR_Z   = 4'd5;
  localparam logic [3:0] F_PLANE_X = 4'd6;
  localparam logic [3:0] F_PLANE_Y = 4'd7;
  localparam logic [3:0] F_CFG     = 4'd8;
  localparam int CAM_FIELDS  = 8;
  localparam int RST_POS     = 2560;
  localparam int RST_DIR_X   = 256;
  localparam int RST_PLANE_Y = 170;
  function automatic int cam_rst_val(input int f);
    return (f <= int'(F_Z)) ? RST_POS :
           (f == int'(F_DIR_X)) ? RST_DIR_X :
           (f == int'(F_PLANE_Y)) ? RST_PLANE_Y : 0;
  endfunction
endpackage

// File: rtl/voxel_frame_sequencer_if.sv
// voxel_frame_sequencer_if: host register bus plus world-generator and raycaster handshakes
interface voxel_frame_sequencer_if;
  logic        host_wr_en;
  logic [7:0]  host_wr_addr;
  logic [31:0] host_wr_data;
  logic        world_start;
  logic        world_done;
  logic        core_start;
  logic        core_busy;
  logic        core_done;
  modport master (
    output host_wr_en, host_wr_addr, host_wr_data, world_done, core_busy, core_done,
    input  world_start, core_start
  );
  modport slave (
    input  host_wr_en, host_wr_addr, host_wr_data, world_done, core_busy, core_done,
    output world_start, core_start
  );
endinterface

// File: rtl/voxel_cam_regfile.sv
// voxel_cam_regfile: per-slot shadow camera/config registers, copied wholesale to the active set on commit
module voxel_cam_regfile
  import voxel_seq_pkg::*;
#(
  parameter int NUM_CAMS = 2,
  parameter int CAM_W    = 16,
  parameter int SLOT_W   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_wr_en,
  input  logic [7:0]           i_wr_addr,
  input  logic [31:0]          i_wr_data,
  input  logic                 i_commit,
  input  logic [SLOT_W-1:0]    i_slot,
  output logic [8*CAM_W-1:0]   o_cam,
  output logic [31:0]          o_cfg
);
  logic [CAM_W-1:0] r_sh  [NUM_CAMS][CAM_FIELDS];
  logic [CAM_W-1:0] r_act [NUM_CAMS][CAM_FIELDS];
  logic [31:0]      r_sh_cfg  [NUM_CAMS];
  logic [31:0]      r_act_cfg [NUM_CAMS];
  logic             w_hit;

  // control/mask addresses alias slot 15 fields 0/1 and must never reach camera storage
  assign w_hit = i_wr_en && i_wr_addr != ADDR_CTRL && i_wr_addr != ADDR_MASK &&
                 int'(i_wr_addr[7:4]) < NUM_CAMS && i_wr_addr[3:0] <= F_CFG;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int s = 0; s < NUM_CAMS; s++) begin
        r_sh_cfg[s]  <= '0;
        r_act_cfg[s] <= '0;
        for (int f = 0; f < CAM_FIELDS; f++) begin
          r_sh[s][f]  <= CAM_W'(cam_rst_val(f));
          r_act[s][f] <= CAM_W'(cam_rst_val(f));
        end
      end
    end else begin
      if (i_commit) begin
        r_act     <= r_sh;
        r_act_cfg <= r_sh_cfg;
      end
      for (int s = 0; s < NUM_CAMS; s++)
        if (w_hit && i_wr_addr[7:4] == 4'(s)) begin
          if (i_wr_addr[3:0] == F_CFG) r_sh_cfg[s] <= i_wr_data;
          for (int f = 0; f < CAM_FIELDS; f++)
            if (i_wr_addr[3:0] == 4'(f)) r_sh[s][f] <= i_wr_data[CAM_W-1:0];
        end
    end

  always_comb begin
    o_cam = '0;
    o_cfg = '0;
    for (int s = 0; s < NUM_CAMS; s++)
      if (i_slot == SLOT_W'(s)) begin
        o_cfg = r_act_cfg[s];
        for (int f = 0; f < CAM_FIELDS; f++) o_cam[f*CAM_W +: CAM_W] = r_act[s][f];
      end
  end
endmodule

// File: rtl/voxel_frame_sequencer.sv
// voxel_frame_sequencer: sequences world generation and per-slot raycast frames
// with round-robin camera selection and a render watchdog
module voxel_frame_sequencer
  import voxel_seq_pkg::*;
#(
  parameter int NUM_CAMS = 2,
  parameter int CAM_W    = 16,
  parameter int CNT_W    = 32,
  parameter int WDOG_W   = 24,
  localparam int SLOT_W  = (NUM_CAMS > 1) ? $clog2(NUM_CAMS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  voxel_frame_sequencer_if.slave bus,
  output logic [8*CAM_W-1:0]   o_cam_active,
  output logic [31:0]          o_cfg_active,
  output logic [SLOT_W-1:0]    o_cam_slot,
  output logic [CNT_W-1:0]     o_frame_count,
  output logic                 o_timeout,
  output logic [2:0]           o_seq_state
);
  localparam logic [WDOG_W-1:0] WDOG_LAST = ~WDOG_W'(1);

  seq_state_e          r_state, w_next;
  logic                r_run, r_trig, r_regen, r_timeout;
  logic [NUM_CAMS-1:0] r_mask;
  logic [SLOT_W-1:0]   r_slot, w_next_slot;
  logic [CNT_W-1:0]    r_frames;
  logic [WDOG_W-1:0]   r_wdog;
  logic                w_ctrl_wr, w_mask_wr, w_launch_ok, w_wdog_exp, w_commit;
  int                  w_best, w_dist;

  assign w_ctrl_wr   = bus.host_wr_en && bus.host_wr_addr == ADDR_CTRL;
  assign w_mask_wr   = bus.host_wr_en && bus.host_wr_addr == ADDR_MASK;
  assign w_launch_ok = (r_run || r_trig) && |r_mask && !bus.core_busy;
  // the increment taking the watchdog to all-ones is the expiring RUN cycle
  assign w_wdog_exp  = r_wdog == WDOG_LAST;
  assign w_commit    = r_state == S_READY && w_next == S_LAUNCH;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = S_WGEN;
      S_WGEN:    w_next = S_WWAIT;
      S_WWAIT:   w_next = bus.world_done ? S_READY : S_WWAIT;
      S_READY:   w_next = r_regen ? S_WGEN : w_launch_ok ? S_LAUNCH : S_READY;
      S_LAUNCH:  w_next = S_RUN;
      S_RUN:     w_next = bus.core_done ? S_ADVANCE : w_wdog_exp ? S_READY : S_RUN;
      S_ADVANCE: w_next = S_READY;
      default:   w_next = S_IDLE;
    endcase
  end

  // pick the enabled slot at the smallest forward distance from the current one
  always_comb begin
    w_next_slot = r_slot;
    w_best      = NUM_CAMS;
    w_dist      = 0;
    for (int c = 0; c < NUM_CAMS; c++) begin
      w_dist = (c + 2*NUM_CAMS - 1 - int'(r_slot)) % NUM_CAMS;
      if (r_mask[c] && w_dist < w_best) begin
        w_best      = w_dist;
        w_next_slot = SLOT_W'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_run     <= 1'b1;
      r_trig    <= 1'b0;
      r_regen   <= 1'b0;
      r_mask    <= NUM_CAMS'(1);
      r_slot    <= '0;
      r_frames  <= '0;
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_timeout <= r_state == S_RUN && !bus.core_done && w_wdog_exp;
      if (w_next == S_WGEN) r_regen <= 1'b0;
      if (w_next == S_LAUNCH) r_trig <= 1'b0;
      if (w_ctrl_wr) begin
        r_run <= bus.host_wr_data[0];
        if (bus.host_wr_data[1]) r_trig <= 1'b1;
        if (bus.host_wr_data[2]) r_regen <= 1'b1;
      end
      if (w_mask_wr) r_mask <= bus.host_wr_data[NUM_CAMS-1:0];
      if (r_state == S_LAUNCH) r_wdog <= '0;
      else if (r_state == S_RUN) r_wdog <= r_wdog + WDOG_W'(1);
      if (r_state == S_ADVANCE) begin
        r_frames <= r_frames + CNT_W'(1);
        r_slot   <= w_next_slot;
      end
    end

  assign bus.world_start = r_state == S_WGEN;
  assign bus.core_start  = r_state == S_LAUNCH;
  assign o_cam_slot      = r_slot;
  assign o_frame_count   = r_frames;
  assign o_timeout       = r_timeout;
  assign o_seq_state     = r_state;

  voxel_cam_regfile #(
    .NUM_CAMS(NUM_CAMS),
    .CAM_W   (CAM_W),
    .SLOT_W  (SLOT_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_en  (bus.host_wr_en),
    .i_wr_addr(bus.host_wr_addr),
    .i_wr_data(bus.host_wr_data),
    .i_commit (w_commit),
    .i_slot   (r_slot),
    .o_cam    (o_cam_active),
    .o_cfg    (o_cfg_active)
  );
endmodule

// File: tb/tb_voxel_frame_sequencer.sv
// tb_voxel_frame_sequencer: directed scenarios against behavioural world/core responders
module tb_voxel_frame_sequencer;
  localparam int NC = 4, CW = 16, CNTW = 32, WW = 4;
  logic clk = 0, rst_n = 0;
  logic [8*CW-1:0] cam_active;
  logic [31:0] cfg_active;
  logic [1:0] cam_slot;
  logic [CNTW-1:0] frame_count;
  logic timeout;
  logic [2:0] seq_state;
  int checks = 0, errors = 0;
  int ws_cnt = 0, cs_cnt = 0, early_cs = 0, wcnt = 0, ccnt = 0, core_lat = 4;
  bit wd_seen = 0, core_auto = 1;
  logic [CW-1:0] last_x, last_dirx;
  logic [1:0] slots[$];

  voxel_frame_sequencer_if bus();

  voxel_frame_sequencer #(.NUM_CAMS(NC), .CAM_W(CW), .CNT_W(CNTW), .WDOG_W(WW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .o_cam_active(cam_active), .o_cfg_active(cfg_active), .o_cam_slot(cam_slot),
    .o_frame_count(frame_count), .o_timeout(timeout), .o_seq_state(seq_state)
  );

  always #5 clk = ~clk;

  // world generator and raycaster responders, driven away from the active edge
  initial begin
    bus.world_done = 0; bus.core_done = 0; bus.core_busy = 0;
    forever begin
      @(negedge clk);
      bus.world_done = 0;
      bus.core_done = 0;
      if (!rst_n) begin
        wd_seen = 0; wcnt = 0; ccnt = 0; bus.core_busy = 0;
      end else begin
        if (wcnt > 0) begin
          wcnt--;
          if (wcnt == 0) begin bus.world_done = 1; wd_seen = 1; end
        end
        if (bus.world_start) begin ws_cnt++; wcnt = 10; end
        if (ccnt > 0) begin
          ccnt--;
          if (ccnt == 0) begin bus.core_done = 1; bus.core_busy = 0; end
        end
        if (bus.core_start) begin
          cs_cnt++;
          if (!wd_seen) early_cs++;
          last_x = cam_active[CW-1:0];
          last_dirx = cam_active[4*CW-1:3*CW];
          slots.push_back(cam_slot);
          if (core_auto) begin bus.core_busy = 1; ccnt = core_lat; end
        end
      end
    end
  end

  task automatic host_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.host_wr_en = 1; bus.host_wr_addr = a; bus.host_wr_data = d;
    @(negedge clk);
    bus.host_wr_en = 0;
  endtask

  task automatic wait_cs(input int n, input string tag);
    int k = 0;
    while (cs_cnt < n && k < 300) begin @(posedge clk); #1; k++; end
    checks++;
    if (cs_cnt < n) begin errors++; $display("FAIL %s: core_start count %0d, wanted %0d", tag, cs_cnt, n); end
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int k = 0;
    while (seq_state !== s && k < 300) begin @(negedge clk); k++; end
    checks++;
    if (seq_state !== s) begin errors++; $display("FAIL %s: state %0d, wanted %0d", tag, seq_state, s); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (seq_state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", seq_state); end
    checks++; if (frame_count !== 0) begin errors++; $display("FAIL rst_frames: got %0d want 0", frame_count); end
    checks++; if (cam_slot !== 0) begin errors++; $display("FAIL rst_slot: got %0d want 0", cam_slot); end
    checks++; if (timeout !== 0 || bus.world_start !== 0 || bus.core_start !== 0) begin errors++; $display("FAIL rst_pulses: to=%b ws=%b cs=%b want 0", timeout, bus.world_start, bus.core_start); end
    checks++; if (cam_active[15:0] !== 16'd2560 || cam_active[127:112] !== 16'd170) begin errors++; $display("FAIL rst_cam: x=%0d plane_y=%0d want 2560/170", cam_active[15:0], cam_active[127:112]); end
    checks++; if (cfg_active !== 0) begin errors++; $display("FAIL rst_cfg: got %h want 0", cfg_active); end
    rst_n = 1;
    @(negedge clk);
    checks++; if (seq_state !== 3'd1 || bus.world_start !== 1) begin errors++; $display("FAIL wgen: state=%0d ws=%b want 1/1", seq_state, bus.world_start); end
    @(negedge clk);
    checks++; if (seq_state !== 3'd2 || bus.world_start !== 0) begin errors++; $display("FAIL wwait: state=%0d ws=%b want 2/0", seq_state, bus.world_start); end
  endtask

  task automatic test_first_frame();
    wait_cs(1, "first_launch");
    checks++; if (ws_cnt !== 1) begin errors++; $display("FAIL first_ws: got %0d want 1", ws_cnt); end
    checks++; if (early_cs !== 0) begin errors++; $display("FAIL early_cs: got %0d want 0", early_cs); end
    checks++; if (last_x !== 16'd2560 || last_dirx !== 16'd256) begin errors++; $display("FAIL first_cam: x=%0d dir_x=%0d want 2560/256", last_x, last_dirx); end
  endtask

  task automatic test_shadow_commit();
    int cs0;
    wait_state(3'd5, "shadow_run");
    cs0 = cs_cnt;
    host_wr(8'h00, 32'h0500);
    checks++; if (cam_active[15:0] !== 16'd2560) begin errors++; $display("FAIL shadow_hold: x=%h want a00", cam_active[15:0]); end
    wait_cs(cs0 + 1, "shadow_next");
    checks++; if (last_x !== 16'h0500) begin errors++; $display("FAIL shadow_commit: x=%h want 0500", last_x); end
  endtask

  task automatic test_mask_rr();
    logic [1:0] exp_s [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    logic [CNTW-1:0] fc1;
    int cs0;
    wait_state(3'd5, "mask_run");
    slots.delete();
    cs0 = cs_cnt;
    host_wr(8'hF1, 32'hA);
    wait_cs(cs0 + 1, "mask_first");
    fc1 = frame_count;
    wait_cs(cs0 + 4, "mask_four");
    host_wr(8'hF0, 32'h0);
    repeat (30) @(negedge clk);
    checks++; if (frame_count - fc1 !== 4) begin errors++; $display("FAIL mask_frames: delta %0d want 4", frame_count - fc1); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (slots[i] !== exp_s[i]) begin errors++; $display("FAIL mask_slot%0d: got %0d want %0d", i, slots[i], exp_s[i]); end
    end
    host_wr(8'hF1, 32'h0);
    host_wr(8'hF0, 32'h3);
    cs0 = cs_cnt;
    repeat (30) @(negedge clk);
    checks++; if (cs_cnt !== cs0 || seq_state !== 3'd3) begin errors++; $display("FAIL mask_zero: launches %0d state %0d want 0/3", cs_cnt - cs0, seq_state); end
    host_wr(8'hF1, 32'h1);
    wait_cs(cs0 + 1, "mask_resume");
  endtask

  task automatic test_single_shot();
    logic [CNTW-1:0] fc0;
    int cs0;
    host_wr(8'hF0, 32'h0);
    repeat (30) @(negedge clk);
    checks++; if (seq_state !== 3'd3) begin errors++; $display("FAIL ss_idle: state %0d want 3", seq_state); end
    fc0 = frame_count;
    cs0 = cs_cnt;
    @(negedge clk);
    bus.host_wr_en = 1; bus.host_wr_addr = 8'hF0; bus.host_wr_data = 32'h2;
    @(negedge clk);
    bus.host_wr_addr = 8'h00; bus.host_wr_data = 32'h0777;
    @(negedge clk);
    bus.host_wr_en = 0;
    checks++; if (seq_state !== 3'd4 || bus.core_start !== 1) begin errors++; $display("FAIL ss_launch: state %0d cs %b want 4/1", seq_state, bus.core_start); end
    checks++; if (cam_active[15:0] !== 16'h0500) begin errors++; $display("FAIL commit_race: x=%h want 0500", cam_active[15:0]); end
    repeat (30) @(negedge clk);
    checks++; if (cs_cnt !== cs0 + 1) begin errors++; $display("FAIL ss_count: launches %0d want 1", cs_cnt - cs0); end
    checks++; if (seq_state !== 3'd3 || frame_count !== fc0 + 1) begin errors++; $display("FAIL ss_after: state %0d frames %0d want 3/%0d", seq_state, frame_count, fc0 + 1); end
    host_wr(8'hF0, 32'h2);
    wait_cs(cs0 + 2, "ss_second");
    checks++; if (last_x !== 16'h0777) begin errors++; $display("FAIL late_write: x=%h want 0777", last_x); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_watchdog();
    logic [CNTW-1:0] fc0;
    logic [2:0] st = '0;
    int runs = 0;
    bit seen = 0;
    core_auto = 0;
    fc0 = frame_count;
    host_wr(8'hF0, 32'h2);
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (seq_state === 3'd5) runs++;
      if (timeout === 1) begin seen = 1; st = seq_state; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL wdog_seen: timeout %b want 1", seen); end
    checks++; if (runs !== 15) begin errors++; $display("FAIL wdog_cycles: got %0d want 15", runs); end
    checks++; if (st !== 3'd3) begin errors++; $display("FAIL wdog_state: got %0d want 3", st); end
    checks++; if (frame_count !== fc0) begin errors++; $display("FAIL wdog_frames: got %0d want %0d", frame_count, fc0); end
    @(negedge clk);
    checks++; if (timeout !== 0 || seq_state !== 3'd3) begin errors++; $display("FAIL wdog_pulse: to=%b state=%0d want 0/3", timeout, seq_state); end
    core_auto = 1;
  endtask

  task automatic test_regen();
    logic [CNTW-1:0] fc0;
    int cs0, ws0;
    host_wr(8'hF0, 32'h2);
    wait_state(3'd5, "regen_run");
    cs0 = cs_cnt; ws0 = ws_cnt; fc0 = frame_count;
    host_wr(8'hF0, 32'h5);
    wait_cs(cs0 + 1, "regen_launch");
    checks++; if (ws_cnt !== ws0 + 1) begin errors++; $display("FAIL regen_ws: got %0d want %0d", ws_cnt, ws0 + 1); end
    checks++; if (frame_count !== fc0 + 1) begin errors++; $display("FAIL regen_frame: got %0d want %0d", frame_count, fc0 + 1); end
  endtask

  task automatic test_reset_midframe();
    int cs0, ws0;
    wait_state(3'd5, "rst_run");
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++; if (seq_state !== 3'd0 || frame_count !== 0 || bus.core_start !== 0) begin errors++; $display("FAIL midrst: state %0d frames %0d cs %b want 0/0/0", seq_state, frame_count, bus.core_start); end
    cs0 = cs_cnt; ws0 = ws_cnt;
    rst_n = 1;
    wait_cs(cs0 + 1, "midrst_launch");
    checks++; if (ws_cnt !== ws0 + 1 || early_cs !== 0) begin errors++; $display("FAIL midrst_order: ws %0d early %0d want 1/0", ws_cnt - ws0, early_cs); end
    checks++; if (last_x !== 16'd2560) begin errors++; $display("FAIL midrst_cam: x=%0d want 2560", last_x); end
  endtask

  initial begin
    bus.host_wr_en = 0; bus.host_wr_addr = '0; bus.host_wr_data = '0;
    test_reset();
    test_first_frame();
    test_shadow_commit();
    test_mask_rr();
    test_single_shot();
    test_watchdog();
    test_regen();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
